// File: rtl/menu_screen_ctrl.sv
// Menu screen for the 96x64 RGB565 OLED: N_ITEMS label rows, blinking '>' cursor,
// browse/confirm/locked selection FSM and a 2-stage pixel pipeline into an external label ROM.
module menu_screen_ctrl #(
  parameter int          N_ITEMS    = 4,
  parameter int          ROW_TOP    = 20,
  parameter int          ROW_H      = 11,
  parameter int          TEXT_X     = 20,
  parameter int          LABEL_W    = 64,
  parameter int          CURSOR_X   = 12,
  parameter int          BLINK_HALF = 25_000_000,
  parameter int          FLASH_HALF = 3_000_000,
  parameter int          FLASH_N    = 3,
  parameter logic [15:0] C_BG       = 16'h0000,
  parameter logic [15:0] C_FG       = 16'hFFFF,
  parameter logic [15:0] C_HL       = 16'hFFE0,
  parameter logic [15:0] C_CUR      = 16'h07E0,
  localparam int         IDX_W      = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             btn_back,
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  output logic [IDX_W-1:0] lbl_item,
  output logic [5:0]       lbl_col,
  output logic [3:0]       lbl_row,
  input  logic             lbl_on,
  output logic [15:0]      oled_data,
  output logic [IDX_W-1:0] sel_index,
  output logic             sel_valid,
  output logic             menu_active,
  output logic [1:0]       state_dbg
);

  localparam int HALF_MAX = (BLINK_HALF > FLASH_HALF) ? BLINK_HALF : FLASH_HALF;
  localparam int CNT_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int TOG_N    = 2 * FLASH_N;
  localparam int TOG_W    = (TOG_N > 1) ? $clog2(TOG_N) : 1;
  localparam int MID      = ROW_H / 2;

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cursor;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;
  logic [CNT_W-1:0] flash_cnt;
  logic             flash_on;
  logic [TOG_W-1:0] tog_cnt;

  logic [IDX_W-1:0] cursor_up;
  logic [IDX_W-1:0] cursor_down;

  assign cursor_up   = (cursor == '0) ? IDX_W'(N_ITEMS - 1) : cursor - IDX_W'(1);
  assign cursor_down = (cursor == IDX_W'(N_ITEMS - 1)) ? '0 : cursor + IDX_W'(1);

  assign sel_index = cursor;
  assign state_dbg = state;

  // sel_valid is a single-cycle strobe with no back-pressure: the consumer must take
  // sel_index in the cycle sel_valid is high; it stays stable for the whole LOCKED state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BROWSE;
      cursor      <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      flash_cnt   <= '0;
      flash_on    <= 1'b1;
      tog_cnt     <= '0;
      sel_valid   <= 1'b0;
      menu_active <= 1'b1;
    end else begin
      sel_valid <= 1'b0;
      case (state)
        BROWSE: begin
          flash_on  <= 1'b1;
          flash_cnt <= '0;
          tog_cnt   <= '0;
          if (btn_sel) begin
            state       <= CONFIRM;
            menu_active <= 1'b0;
            flash_on    <= 1'b0;
            blink_on    <= 1'b1;
            blink_cnt   <= '0;
          end else if (btn_up ^ btn_down) begin
            cursor    <= btn_up ? cursor_up : cursor_down;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
          end else if (blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
          end
        end
        CONFIRM: begin
          blink_on  <= 1'b1;
          blink_cnt <= '0;
          if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
            flash_cnt <= '0;
            // The final toggle hands over to LOCKED with the row shown steadily highlighted.
            if (tog_cnt == TOG_W'(TOG_N - 1)) begin
              state     <= LOCKED;
              sel_valid <= 1'b1;
              flash_on  <= 1'b1;
              tog_cnt   <= '0;
            end else begin
              flash_on <= ~flash_on;
              tog_cnt  <= tog_cnt + TOG_W'(1);
            end
          end else begin
            flash_cnt <= flash_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          blink_on  <= 1'b1;
          blink_cnt <= '0;
          flash_on  <= 1'b1;
          if (btn_back) begin
            state       <= BROWSE;
            menu_active <= 1'b1;
          end
        end
        default: begin
          state       <= BROWSE;
          menu_active <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1 geometry: which row (if any) the pixel falls on and its position inside it.
  int               x_i;
  int               y_i;
  int               line_i;
  logic             hit_row;
  logic [IDX_W-1:0] row_idx;
  logic             hit_label;
  logic             hit_glyph;

  assign x_i = int'(x);
  assign y_i = int'(y);

  always_comb begin
    hit_row = 1'b0;
    row_idx = '0;
    line_i  = 0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if ((y_i >= ROW_TOP + i * ROW_H) && (y_i < ROW_TOP + (i + 1) * ROW_H)) begin
        hit_row = 1'b1;
        row_idx = IDX_W'(i);
        line_i  = y_i - ROW_TOP - i * ROW_H;
      end
    end
  end

  assign hit_label = hit_row && (x_i >= TEXT_X) && (x_i < TEXT_X + LABEL_W);
  assign hit_glyph = hit_row &&
                     (((x_i == CURSOR_X) && ((line_i == MID - 1) || (line_i == MID + 1))) ||
                      ((x_i == CURSOR_X + 1) && (line_i == MID)));

  logic s1_label;
  logic s1_glyph;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_label <= 1'b0;
      s1_glyph <= 1'b0;
      lbl_item <= '0;
      lbl_col  <= '0;
      lbl_row  <= '0;
    end else begin
      s1_label <= hit_label;
      s1_glyph <= hit_glyph;
      lbl_item <= hit_row ? row_idx : '0;
      lbl_col  <= hit_label ? 6'(x_i - TEXT_X) : '0;
      lbl_row  <= hit_row ? 4'(line_i) : '0;
    end
  end

  // Stage 2: the glyph shape was found in stage 1; its row is matched against the live cursor here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oled_data <= C_BG;
    end else if (s1_glyph && (lbl_item == cursor) && blink_on) begin
      oled_data <= C_CUR;
    end else if (s1_label && lbl_on) begin
      oled_data <= ((lbl_item == cursor) && flash_on) ? C_HL : C_FG;
    end else begin
      oled_data <= C_BG;
    end
  end

endmodule
